// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: load/store codes, access sizes and FSM state encodings
package mem_access_unit_pkg;
  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_SB   = 3'd1;
  localparam logic [2:0] LD_UB   = 3'd2;
  localparam logic [2:0] LD_SH   = 3'd3;
  localparam logic [2:0] LD_UH   = 3'd4;
  localparam logic [2:0] LD_W    = 3'd5;
  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_B    = 2'd1;
  localparam logic [1:0] ST_H    = 2'd2;
  localparam logic [1:0] ST_W    = 2'd3;
  localparam logic [1:0] SZ_B    = 2'd0;
  localparam logic [1:0] SZ_H    = 2'd1;
  localparam logic [1:0] SZ_W    = 2'd2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store lane replication, load extraction/extension
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_code,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] ext
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane steering for the outgoing request and extension of the returning word
  always_comb begin
    be = size == SZ_B ? 4'b0001 << lane : size == SZ_H ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
    wrep = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
    b = 8'(word >> {ld_lane, 3'b000});
    h = 16'(word >> {ld_lane[1], 4'b0000});
    ext = ld_code == LD_SB ? {{24{b[7]}}, b} :
          ld_code == LD_UB ? {24'd0, b} :
          ld_code == LD_SH ? {{16{h[15]}}, h} :
          ld_code == LD_UH ? {16'd0, h} : word;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store bus master with stall, timeout and alignment checks
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Memread,
  input  logic [1:0]  Memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic            rd, wr, conflict, aligned, go;
  logic [1:0]      size, state, lane;
  logic [2:0]      ld_code;
  logic [TO_W-1:0] cnt;
  logic [3:0]      be;
  logic [31:0]     wrep, ext;
  mem_lane_align u_align (
    .size(size), .lane(addr[1:0]), .wdata(wdata),
    .ld_code(ld_code), .ld_lane(lane), .word(bus_rdata),
    .be(be), .wrep(wrep), .ext(ext)
  );
  // decode the request: kind, size, alignment and whether it can be launched now
  always_comb begin
    rd = Memread >= LD_SB && Memread <= LD_W;
    wr = Memwrite != ST_NONE;
    conflict = rd && wr;
    size = rd ? ((Memread == LD_SB || Memread == LD_UB) ? SZ_B : (Memread == LD_SH || Memread == LD_UH) ? SZ_H : SZ_W)
              : (Memwrite == ST_B ? SZ_B : Memwrite == ST_H ? SZ_H : SZ_W);
    aligned = size == SZ_H ? !addr[0] : size == SZ_W ? addr[1:0] == 2'b00 : 1'b1;
    go = state == S_IDLE && (rd ^ wr) && aligned;
  end
  assign stall = go || state == S_WAIT;
  // access FSM: launch, wait for ack or timeout, one completion cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
      cnt <= '0;
      ld_code <= LD_NONE;
      lane <= 2'b00;
    end else begin
      rdata_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            bus_req <= 1'b1;
            bus_we <= wr;
            bus_addr <= {addr[31:2], 2'b00};
            bus_be <= be;
            bus_wdata <= wrep;
            cnt <= '0;
            ld_code <= rd ? Memread : LD_NONE;
            lane <= addr[1:0];
            state <= S_WAIT;
          end else if (conflict) bus_err <= 1'b1;
          else if (rd || wr) misalign <= 1'b1;
        end
        S_WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            rdata <= ld_code != LD_NONE ? ext : rdata;
            rdata_valid <= ld_code != LD_NONE;
            state <= S_DONE;
          end else if (cnt == TO_LAST) begin
            bus_req <= 1'b0;
            rdata <= '0;
            bus_err <= 1'b1;
            state <= S_DONE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory side of the decoder's Memread/Memwrite control interface. It consumes the 3-bit load code and 2-bit store code plus the ALU address and store data.
- Drives a single-outstanding request/acknowledge memory bus with byte enables.
- Returns sign- or zero-extended load data to writeback.
- Holds the pipeline with stall until the access completes.

Parameters:
- TIMEOUT, 16: maximum cycles in WAIT_ACK before the access aborts with bus_err.
- TO_W, 5: width of the timeout counter. TO_W must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- Memread  in  3  load code: noexec=0, signbyte=1, unsignbyte=2, signhalf=3, unsignhalf=4, readword=5; 6 and 7 are reserved and treated as noexec
- Memwrite  in  2  store code: none=0, byte=1, half=2, writeword=3
- addr  in  32  byte address from the ALU
- wdata  in  32  store data; low byte/half/word is used
- stall  out  1  holds the pipeline
- rdata  out  32  extended load result
- rdata_valid  out  1  one-cycle pulse when rdata is valid for a load
- misalign  out  1  one-cycle pulse: misaligned request rejected
- bus_err  out  1  one-cycle pulse: timeout or read/write conflict
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2], 2'b00}
- bus_be  out  4  byte enables; bit i corresponds to bits 8i+7:8i
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion
- bus_rdata  in  32  read data, valid when bus_ack=1

Behaviour:
- Reset values (async): state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rdata=0, rdata_valid=0, misalign=0, bus_err=0, timeout counter=0. A reset mid-access abandons the access; bus_req drops immediately.
- Little-endian byte lanes: lane = addr[1:0].
- Request valid: rd = Memread in 1..5; wr = Memwrite != 0.
- Conflict (rd and wr both asserted):
  - no bus access;
  - bus_err pulses the next cycle;
  - stall stays 0.
- Alignment:
  - half access with addr[0]=1 is misaligned;
  - word access with addr[1:0]!=0 is misaligned;
  - on misalignment: no bus access, misalign pulses the next cycle, stall stays 0.
- Byte enables:
  - byte: 4'b0001<<addr[1:0];
  - half: 4'b0011<<{addr[1],1'b0};
  - word: 4'b1111.
- Store data: bus_wdata replicates wdata[7:0] x4 for byte, wdata[15:0] x2 for half, and wdata for word.
- FSM states: IDLE, WAIT_ACK, DONE.
- IDLE:
  - on a valid, aligned, non-conflicting request, register bus_addr, bus_be, bus_we and bus_wdata, set bus_req=1, clear the counter, and move to WAIT_ACK;
  - the request type and addr[1:0] are latched internally.
- WAIT_ACK:
  - bus outputs stay stable; the counter increments each cycle;
  - bus_ack=1: drop bus_req, capture bus_rdata, go to DONE;
  - counter==TIMEOUT-1 without ack: drop bus_req, rdata=0, pulse bus_err, go to DONE;
  - bus_ack is ignored outside WAIT_ACK.
- DONE:
  - rdata_valid=1 for one cycle if a load completed without error;
  - stall=0;
  - always returns to IDLE.
  - The request inputs are still present this cycle and are not re-accepted; the pipeline advances on this edge.
- stall (combinational) = (IDLE && valid && aligned && !conflict) || WAIT_ACK.
- Load extraction from the captured word, using the latched lane:
  - byte = word >> (8*lane), low 8 bits;
  - half = word >> (16*addr[1]), low 16 bits;
  - signbyte/signhalf sign-extend; unsignbyte/unsignhalf zero-extend; readword passes through.
- Minimum latency: request seen in cycle 0, bus_req high in cycle 1, ack in cycle 1, rdata_valid in cycle 2.
- rdata holds its value until the next completed load.

Decomposition:
- Newdefine.h holds the Memread/Memwrite encodings (noexec, signbyte, unsignbyte, signhalf, unsignhalf, readword, none, byte, half, writeword) and the state encodings.
- Sub-module mem_lane_align (combinational) holds the byte-enable/wdata replication and load extraction/extension. The FSM and counter stay in the top.

Test Plan:
- lb, addr=0x1003, bus_rdata=0x80FF1234, ack 1 cycle after req -> bus_addr=0x1000, bus_be=4'b1000, rdata=0xFFFFFF80, rdata_valid in cycle 2, stall high cycles 0-1.
- lhu, addr=0x2002, bus_rdata=0xBEEF0001 -> bus_be=4'b1100, rdata=0x0000BEEF.
- sh, addr=0x0006, wdata=0x1234ABCD, ack after 3 wait cycles -> bus_we=1, bus_be=4'b1100, bus_wdata=0xABCDABCD, bus_req high 4 cycles, no rdata_valid.
- lw, addr=0x0102 -> misalign pulse, bus_req never asserted, stall=0; sh at addr=0x0001 gives the same result.
- lw with no ack, TIMEOUT=16 -> bus_req high 16 cycles, then bus_err pulse, rdata=0, return to IDLE.
- rst asserted during WAIT_ACK -> bus_req=0 and stall=0 immediately; a later ack is ignored; the next lb completes normally.
